simple_add_stream_arb: RTL and testbench
========================================

SIMPLE_ADD_STREAM_ARB -- requirements
Module: simple_add_stream_arb

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 512: tdata width of all streams (multiple of 8).
REQ-002 SHALL have parameter C_CNT_WIDTH, default 32: width of the status counters.
REQ-003 SHALL have port ap_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports axis_S0_tvalid/tready/tdata/tkeep/tlast/tdest  in/out/in/in/in/in  1/1/W/W/8/1/16  requester 0 stream.
REQ-006 SHALL have ports axis_S1_tvalid/tready/tdata/tkeep/tlast/tdest  in/out/in/in/in/in  1/1/W/W/8/1/16  requester 1 stream.
REQ-007 SHALL have ports axis_M_tvalid/tready/tdata/tkeep/tlast/tdest  out/in/out/out/out/out  1/1/W/W/8/1/16  shared stream to the vadd datapath.
REQ-008 SHALL have port grant_id  output  1  requester owning axis_M (valid while busy).
REQ-009 SHALL have port busy  output  1  high while a packet is in progress.
REQ-010 SHALL have ports pkt_count_0 / pkt_count_1  output  C_CNT_WIDTH each  packets completed per requester.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY; reset state IDLE.
REQ-012 IDLE: if exactly one requester has tvalid high, SHALL grant it; if both, SHALL grant the one not equal to last_grant (round-robin); then move to BUSY next cycle.
REQ-013 IDLE with no tvalid SHALL remain IDLE; no beats accepted in IDLE (both tready low).
REQ-014 BUSY: only the granted requester's tready SHALL be driven, equal to (~axis_M_tvalid | axis_M_tready); the other tready SHALL be 0.
REQ-015 Output SHALL be one register stage: accepted beat (tdata, tkeep, tlast, tdest unchanged) appears on axis_M the cycle after acceptance; latency exactly 1 cycle.
REQ-016 axis_M_tvalid/tdata/tkeep/tlast/tdest SHALL hold stable while tvalid=1 and tready=0.
REQ-017 Grant SHALL be packet-locked: no switch until the beat with tlast=1 is accepted from the granted requester.
REQ-018 On acceptance of a tlast beat: FSM -> IDLE, last_grant <= grant_id, pkt_count_<grant> += 1 (modulo 2^C_CNT_WIDTH, wraps to 0).
REQ-019 Output register SHALL drain independently of FSM; a new grant MAY be issued while the final beat is still held on axis_M.
REQ-020 Simultaneous output handshake and input acceptance in the same cycle SHALL reload the register with no bubble (full throughput: one beat/cycle in BUSY).
REQ-021 busy SHALL equal (state==BUSY); grant_id SHALL hold its value in IDLE.
REQ-022 tkeep SHALL be forwarded unmodified; the block SHALL NOT inspect tdata.

Reset
REQ-023 On ap_rst_n=0 (any cycle, including mid-packet) SHALL asynchronously force: state IDLE, axis_M_tvalid 0, both tready 0, busy 0, grant_id 0, last_grant 1 (so requester 0 wins first tie), pkt_count_0/1 0; axis_M_tdata/tkeep/tlast/tdest 0.
REQ-024 A packet interrupted by reset SHALL be discarded; no partial beats emitted after reset release.
REQ-025 Reset deassertion SHALL be synchronised internally so the FSM leaves reset on a clean ap_clk edge.

Verification
REQ-026 Single requester: S0 sends 4-beat packet (tdata 1..4, tdest 0x0005), M tready=1 -> M emits 1..4, tdest 0x0005, tlast on beat 4, pkt_count_0=1, busy falls after beat 4 accepted.
REQ-027 Contention: S0 and S1 both valid from reset with 2-beat packets, repeated x3 -> grant order 0,1,0,1,0,1; no interleaving of beats within a packet.
REQ-028 Backpressure: M tready toggles 1,0,0,1 during a 3-beat packet -> output stable during stalls, no loss/duplication, all 3 beats in order.
REQ-029 Reset mid-packet: assert ap_rst_n=0 after beat 2 of 4 -> axis_M_tvalid 0 same cycle, counters 0; after release, next S1 packet granted and passed intact.
REQ-030 Counter wrap: with C_CNT_WIDTH=4, 17 S0 packets -> pkt_count_0=1.
REQ-031 Throughput: S0 8-beat packet, tvalid and M tready constantly 1 -> 8 consecutive output beats with no gap; 1-cycle gap only at IDLE arbitration.

Source files
------------

// File: rtl/simple_add_stream_arb.sv
// simple_add_stream_arb
//   Two-requester AXI-Stream arbiter in front of the vadd datapath.
//   The arbiter grants one requester per packet and locks that grant until
//   the tlast beat is accepted. When both requesters are valid at the same
//   time, round-robin picks the one that did not win last. Each beat is
//   forwarded through a single output register. The register empties on
//   its own, so the FSM can issue a new grant while the final beat is
//   still waiting on axis_M.
// Ports:
//   ap_clk, ap_rst_n  clock; reset is active-low. It asserts asynchronously
//                     and is released synchronously inside the block.
//   axis_S0_*         requester 0 input stream (tvalid/tready/tdata/tkeep/tlast/tdest)
//   axis_S1_*         requester 1 input stream
//   axis_M_*          shared output stream (registered, 1-cycle latency)
//   grant_id          requester that owns axis_M; holds its value in IDLE
//   busy              high while a packet is in progress (state == BUSY)
//   pkt_count_0/1     packets completed per requester, wrapping
module simple_add_stream_arb #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_CNT_WIDTH        = 32
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,

  input  logic                            axis_S0_tvalid,
  output logic                            axis_S0_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   axis_S0_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] axis_S0_tkeep,
  input  logic                            axis_S0_tlast,
  input  logic [15:0]                     axis_S0_tdest,

  input  logic                            axis_S1_tvalid,
  output logic                            axis_S1_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   axis_S1_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] axis_S1_tkeep,
  input  logic                            axis_S1_tlast,
  input  logic [15:0]                     axis_S1_tdest,

  output logic                            axis_M_tvalid,
  input  logic                            axis_M_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   axis_M_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] axis_M_tkeep,
  output logic                            axis_M_tlast,
  output logic [15:0]                     axis_M_tdest,

  output logic                            grant_id,
  output logic                            busy,
  output logic [C_CNT_WIDTH-1:0]          pkt_count_0,
  output logic [C_CNT_WIDTH-1:0]          pkt_count_1
);

  localparam int KW = C_AXIS_TDATA_WIDTH / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_next;
  logic   grant_next;
  logic   last_grant, last_grant_next;
  logic   inc_0, inc_1;

  // Reset asserts immediately; release passes through two flops so all
  // other state leaves reset on a clean ap_clk edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Selected-requester view of the input streams
  logic                          sel_valid, sel_last, sel_fire, out_free;
  logic [C_AXIS_TDATA_WIDTH-1:0] sel_data;
  logic [KW-1:0]                 sel_keep;
  logic [15:0]                   sel_dest;

  assign busy      = (state == BUSY);
  assign out_free  = ~axis_M_tvalid | axis_M_tready;
  assign axis_S0_tready = busy & ~grant_id & out_free;
  assign axis_S1_tready = busy &  grant_id & out_free;

  assign sel_valid = grant_id ? axis_S1_tvalid : axis_S0_tvalid;
  assign sel_last  = grant_id ? axis_S1_tlast  : axis_S0_tlast;
  assign sel_data  = grant_id ? axis_S1_tdata  : axis_S0_tdata;
  assign sel_keep  = grant_id ? axis_S1_tkeep  : axis_S0_tkeep;
  assign sel_dest  = grant_id ? axis_S1_tdest  : axis_S0_tdest;
  assign sel_fire  = sel_valid & busy & out_free;

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_id    <= 1'b0;
      last_grant  <= 1'b1;
      pkt_count_0 <= '0;
      pkt_count_1 <= '0;
    end else begin
      state      <= state_next;
      grant_id   <= grant_next;
      last_grant <= last_grant_next;
      if (inc_0) pkt_count_0 <= pkt_count_0 + C_CNT_WIDTH'(1);
      if (inc_1) pkt_count_1 <= pkt_count_1 + C_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant_id;
    last_grant_next = last_grant;
    inc_0           = 1'b0;
    inc_1           = 1'b0;
    unique case (state)
      IDLE: begin
        if (axis_S0_tvalid | axis_S1_tvalid) begin
          // on a tie, pick the requester that did not win last time
          grant_next = (axis_S0_tvalid & axis_S1_tvalid) ? ~last_grant : axis_S1_tvalid;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (sel_fire & sel_last) begin
          state_next      = IDLE;
          last_grant_next = grant_id;
          inc_0           = ~grant_id;
          inc_1           =  grant_id;
        end
      end
    endcase
  end

  // Output register: a new beat reloads it even while the previous beat is
  // leaving, so BUSY sustains one beat per cycle.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_M_tvalid <= 1'b0;
      axis_M_tdata  <= '0;
      axis_M_tkeep  <= '0;
      axis_M_tlast  <= 1'b0;
      axis_M_tdest  <= '0;
    end else if (sel_fire) begin
      axis_M_tvalid <= 1'b1;
      axis_M_tdata  <= sel_data;
      axis_M_tkeep  <= sel_keep;
      axis_M_tlast  <= sel_last;
      axis_M_tdest  <= sel_dest;
    end else if (axis_M_tready) begin
      axis_M_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simple_add_stream_arb.sv
module tb_simple_add_stream_arb;

  localparam int W  = 64;
  localparam int KW = W / 8;
  localparam int CW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b1;
  logic          s0_valid = 1'b0, s0_ready, s0_last = 1'b0;
  logic [W-1:0]  s0_data = '0;
  logic [KW-1:0] s0_keep = '0;
  logic [15:0]   s0_dest = '0;
  logic          s1_valid = 1'b0, s1_ready, s1_last = 1'b0;
  logic [W-1:0]  s1_data = '0;
  logic [KW-1:0] s1_keep = '0;
  logic [15:0]   s1_dest = '0;
  logic          m_valid, m_ready = 1'b0, m_last;
  logic [W-1:0]  m_data;
  logic [KW-1:0] m_keep;
  logic [15:0]   m_dest;
  logic          grant_id, busy;
  logic [CW-1:0] pkt_count_0, pkt_count_1;

  simple_add_stream_arb #(.C_AXIS_TDATA_WIDTH(W), .C_CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .axis_S0_tvalid(s0_valid), .axis_S0_tready(s0_ready), .axis_S0_tdata(s0_data),
    .axis_S0_tkeep(s0_keep), .axis_S0_tlast(s0_last), .axis_S0_tdest(s0_dest),
    .axis_S1_tvalid(s1_valid), .axis_S1_tready(s1_ready), .axis_S1_tdata(s1_data),
    .axis_S1_tkeep(s1_keep), .axis_S1_tlast(s1_last), .axis_S1_tdest(s1_dest),
    .axis_M_tvalid(m_valid), .axis_M_tready(m_ready), .axis_M_tdata(m_data),
    .axis_M_tkeep(m_keep), .axis_M_tlast(m_last), .axis_M_tdest(m_dest),
    .grant_id(grant_id), .busy(busy),
    .pkt_count_0(pkt_count_0), .pkt_count_1(pkt_count_1)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic [15:0]   dest;
    bit            src;
  } beat_t;

  int tests_run = 0;
  int failed    = 0;

  // stimulus queues (one per requester) and expected output stream
  beat_t q0[$], q1[$], mq[$];
  bit    rdy_pat[$];
  bit    rand_ready = 0;

  // observations collected by the monitor
  bit           out_order[$];
  logic [W-1:0] out_data[$];
  int           out_cyc[$], in_cyc[$];
  int           cyc = 0, stalls = 0, exp_cnt0 = 0, exp_cnt1 = 0;

  // monitor state
  beat_t        mb, ib, pb;
  bit           pfire = 0, pstall = 0, in_open = 0, in_src = 0, f;
  logic [W-1:0] ps_data;
  logic [KW-1:0] ps_keep;
  logic         ps_last;
  logic [15:0]  ps_dest;

  // Cycle-level scoreboard: sampled on the falling edge, after inputs
  // (driven just after the rising edge) and DUT state have settled.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      mq.delete(); out_order.delete(); out_data.delete(); out_cyc.delete(); in_cyc.delete();
      exp_cnt0 = 0; exp_cnt1 = 0; stalls = 0;
      pfire = 0; pstall = 0; in_open = 0;
    end else begin
      cyc++;
      tests_run++;
      if ((s0_ready && s1_ready) || (!busy && (s0_ready || s1_ready))) begin
        failed++;
        $display("FAIL tready_excl: s0=%0b s1=%0b busy=%0b, required at most granted one", s0_ready, s1_ready, busy);
      end
      if (pfire) begin
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== pb.data || m_keep !== pb.keep || m_last !== pb.last || m_dest !== pb.dest) begin
          failed++;
          $display("FAIL latency: got v=%0b d=%h dest=%h, required v=1 d=%h dest=%h", m_valid, m_data, m_dest, pb.data, pb.dest);
        end
      end
      if (pstall) begin
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== ps_data || m_keep !== ps_keep || m_last !== ps_last || m_dest !== ps_dest) begin
          failed++;
          $display("FAIL stall_stable: got v=%0b d=%h, required v=1 d=%h", m_valid, m_data, ps_data);
        end
      end
      if (m_valid && m_ready) begin
        tests_run++;
        if (mq.size() == 0) begin
          failed++;
          $display("FAIL out_unexpected: got d=%h, required no beat", m_data);
        end else begin
          mb = mq.pop_front();
          if (m_data !== mb.data || m_keep !== mb.keep || m_last !== mb.last || m_dest !== mb.dest) begin
            failed++;
            $display("FAIL out_beat: got d=%h k=%h l=%0b dest=%h, required d=%h k=%h l=%0b dest=%h",
                     m_data, m_keep, m_last, m_dest, mb.data, mb.keep, mb.last, mb.dest);
          end
          if (mb.last) out_order.push_back(mb.src);
        end
        out_data.push_back(m_data);
        out_cyc.push_back(cyc);
      end
      pfire = 0;
      for (int s = 0; s < 2; s++) begin
        f = (s == 0) ? (s0_valid && s0_ready) : (s1_valid && s1_ready);
        if (f) begin
          ib = (s == 0) ? q0.pop_front() : q1.pop_front();
          tests_run++;
          if (busy !== 1'b1 || grant_id !== 1'(s) || (in_open && in_src != 1'(s))) begin
            failed++;
            $display("FAIL accept_owner: src=%0d busy=%0b grant=%0b open_src=%0b, required owner %0d", s, busy, grant_id, in_src, s);
          end
          in_open = !ib.last;
          in_src  = 1'(s);
          mq.push_back(ib);
          in_cyc.push_back(cyc);
          if (ib.last) begin
            if (s == 0) exp_cnt0++; else exp_cnt1++;
          end
          pb = ib;
          pfire = 1;
        end
      end
      pstall  = m_valid && !m_ready;
      if (pstall) stalls++;
      ps_data = m_data; ps_keep = m_keep; ps_last = m_last; ps_dest = m_dest;
    end
  end

  // one clock of stimulus: present queue heads, choose M tready
  task automatic cycle();
    beat_t b;
    s0_valid = (q0.size() > 0);
    if (s0_valid) begin b = q0[0]; s0_data = b.data; s0_keep = b.keep; s0_last = b.last; s0_dest = b.dest; end
    s1_valid = (q1.size() > 0);
    if (s1_valid) begin b = q1[0]; s1_data = b.data; s1_keep = b.keep; s1_last = b.last; s1_dest = b.dest; end
    if (rdy_pat.size() > 0) m_ready = rdy_pat.pop_front();
    else                    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic add_pkt(input bit src, input int len, input logic [15:0] dest, input bit seq, input logic [W-1:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = seq ? base + W'(i) : {$urandom, $urandom};
      b.keep = seq ? '1 : KW'($urandom);
      b.last = (i == len - 1);
      b.dest = dest;
      b.src  = src;
      if (src) q1.push_back(b); else q0.push_back(b);
    end
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    q0.delete(); q1.delete(); rdy_pat.delete();
    s0_valid = 1'b0; s1_valid = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
  endtask

  task automatic run_until_done(input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || mq.size() > 0 || m_valid) && n < max) begin
      cycle();
      n++;
    end
    tests_run++;
    if (n >= max) begin
      failed++;
      $display("FAIL timeout: %0d cycles used, required fewer than %0d", n, max);
    end
  endtask

  task automatic test_reset();
    @(posedge ap_clk); #2 ap_rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0 ||
        pkt_count_0 !== '0 || pkt_count_1 !== '0 || m_data !== '0 || m_keep !== '0 || m_last !== 1'b0 || m_dest !== '0) begin
      failed++;
      $display("FAIL reset_state: v=%0b busy=%0b grant=%0b c0=%0d c1=%0d d=%h, required all zero",
               m_valid, busy, grant_id, pkt_count_0, pkt_count_1, m_data);
    end
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failed++;
      $display("FAIL idle_no_input: busy=%0b v=%0b, required 0 0", busy, m_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    rand_ready = 0;
    add_pkt(0, 4, 16'h0005, 1, 64'd1);
    run_until_done(40);
    tests_run++;
    if (out_data.size() != 4) begin
      failed++;
      $display("FAIL single_len: got %0d beats, required 4", out_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (out_data[i] !== W'(i + 1)) begin
          failed++;
          $display("FAIL single_data[%0d]: got %h, required %0d", i, out_data[i], i + 1);
        end
      end
    end
    tests_run++;
    if (pkt_count_0 !== 4'd1 || pkt_count_1 !== 4'd0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL single_count: c0=%0d c1=%0d busy=%0b, required 1 0 0", pkt_count_0, pkt_count_1, busy);
    end
  endtask

  task automatic test_contention();
    bit exp_order[6] = '{0, 1, 0, 1, 0, 1};
    do_reset();
    rand_ready = 0;
    for (int k = 0; k < 3; k++) begin
      add_pkt(0, 2, 16'h0010, 0, '0);
      add_pkt(1, 2, 16'h8011, 0, '0);
    end
    run_until_done(80);
    tests_run++;
    if (out_order.size() != 6) begin
      failed++;
      $display("FAIL contention_pkts: got %0d packets, required 6", out_order.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (out_order[i] !== exp_order[i]) begin
          failed++;
          $display("FAIL contention_order[%0d]: got %0d, required %0d", i, out_order[i], exp_order[i]);
        end
      end
    end
    tests_run++;
    if (pkt_count_0 !== 4'd3 || pkt_count_1 !== 4'd3 || grant_id !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL contention_end: c0=%0d c1=%0d grant=%0b busy=%0b, required 3 3 1 0", pkt_count_0, pkt_count_1, grant_id, busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rand_ready = 0;
    add_pkt(0, 3, 16'h0042, 1, 64'h100);
    // IDLE, first accept, then M tready 1,0,0,1 while beats are on axis_M
    rdy_pat = '{1, 1, 1, 0, 0, 1};
    run_until_done(40);
    tests_run++;
    if (out_data.size() != 3 || stalls != 2) begin
      failed++;
      $display("FAIL bp_count: got %0d beats %0d stalls, required 3 beats 2 stalls", out_data.size(), stalls);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (out_data[i] !== 64'h100 + W'(i)) begin
          failed++;
          $display("FAIL bp_data[%0d]: got %h, required %h", i, out_data[i], 64'h100 + W'(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    rand_ready = 0;
    add_pkt(0, 4, 16'h0003, 1, 64'hA0);
    while (out_data.size() < 2 && n < 20) begin cycle(); n++; end
    ap_rst_n = 1'b0;
    #1;
    tests_run++;
    if (n >= 20 || m_valid !== 1'b0 || s0_ready !== 1'b0 || busy !== 1'b0 || pkt_count_0 !== '0 || pkt_count_1 !== '0) begin
      failed++;
      $display("FAIL reset_mid: n=%0d v=%0b rdy=%0b busy=%0b c0=%0d, required v=0 rdy=0 busy=0 c0=0", n, m_valid, s0_ready, busy, pkt_count_0);
    end
    do_reset();
    add_pkt(1, 2, 16'h8077, 0, '0);
    run_until_done(40);
    tests_run++;
    if (out_order.size() != 1 || out_data.size() != 2 || pkt_count_1 !== 4'd1 || pkt_count_0 !== 4'd0) begin
      failed++;
      $display("FAIL reset_mid_after: pkts=%0d beats=%0d c0=%0d c1=%0d, required 1 2 0 1",
               out_order.size(), out_data.size(), pkt_count_0, pkt_count_1);
    end else begin
      tests_run++;
      if (out_order[0] !== 1'b1) begin
        failed++;
        $display("FAIL reset_mid_src: got %0d, required 1", out_order[0]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    rand_ready = 0;
    for (int k = 0; k < 17; k++) add_pkt(0, 1, 16'h0001, 0, '0);
    run_until_done(200);
    tests_run++;
    if (pkt_count_0 !== 4'd1 || exp_cnt0 != 17) begin
      failed++;
      $display("FAIL wrap: c0=%0d sent=%0d, required c0=1 sent=17", pkt_count_0, exp_cnt0);
    end
  endtask

  task automatic test_throughput();
    int c0;
    do_reset();
    rand_ready = 0;
    c0 = cyc;
    add_pkt(0, 8, 16'h0009, 1, 64'h200);
    run_until_done(40);
    tests_run++;
    if (out_cyc.size() != 8 || in_cyc.size() != 8) begin
      failed++;
      $display("FAIL tput_count: out=%0d in=%0d, required 8 8", out_cyc.size(), in_cyc.size());
    end else begin
      tests_run++;
      if (in_cyc[0] != c0 + 2) begin
        failed++;
        $display("FAIL tput_first_accept: got cycle %0d, required %0d", in_cyc[0] - c0, 2);
      end
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (out_cyc[i] != c0 + 3 + i) begin
          failed++;
          $display("FAIL tput_beat[%0d]: got cycle %0d, required %0d", i, out_cyc[i] - c0, 3 + i);
        end
      end
    end
  endtask

  task automatic test_random();
    bit s;
    do_reset();
    rand_ready = 1;
    for (int k = 0; k < 30; k++) begin
      s = 1'($urandom_range(0, 1));
      add_pkt(s, $urandom_range(1, 5), {s, 15'($urandom)}, 0, '0);
      repeat ($urandom_range(0, 6)) cycle();
    end
    run_until_done(2000);
    tests_run++;
    if (pkt_count_0 !== CW'(exp_cnt0) || pkt_count_1 !== CW'(exp_cnt1) || exp_cnt0 + exp_cnt1 != 30) begin
      failed++;
      $display("FAIL random_counts: c0=%0d c1=%0d, required %0d %0d (total 30, got %0d)",
               pkt_count_0, pkt_count_1, CW'(exp_cnt0), CW'(exp_cnt1), exp_cnt0 + exp_cnt1);
    end
    rand_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_throughput();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
